// File: rtl/oled_page_streamer_pkg.sv
// oled_pkg: shared constants and FSM state encoding for oled_page_streamer.
//   H_PIXELS / V_PIXELS / PAGES : panel geometry (128x64, 8 pages of 8 rows)
//   CMD_*                       : SSD1306 page-addressing command bytes
//   state_t                     : streamer FSM states
package oled_pkg;

  localparam int unsigned H_PIXELS = 128;
  localparam int unsigned V_PIXELS = 64;
  localparam int unsigned PAGES    = V_PIXELS / 8;

  localparam logic [7:0] CMD_PAGE_BASE = 8'hB0;
  localparam logic [7:0] CMD_COL_LO    = 8'h00;
  localparam logic [7:0] CMD_COL_HI    = 8'h10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD_PAGE,
    ST_CMD_COLLO,
    ST_CMD_COLHI,
    ST_FETCH,
    ST_CAPTURE,
    ST_SEND_DATA,
    ST_FINISH
  } state_t;

endpackage

// File: rtl/oled_page_streamer.sv
// oled_page_streamer: walks the 128x64 monochrome framebuffer page by page and
// streams SSD1306 page-address commands followed by 128 bit-reordered column
// bytes on a valid/ready byte stream.
//   clk, rst        : clock, asynchronous active-high reset
//   start           : frame refresh request (sampled in IDLE)
//   busy, done      : frame in progress / one-cycle end-of-frame pulse
//   fb_re, fb_xpos, fb_ypos, fb_r_mode, fb_dout : framebuffer column read port
//   m_data, m_dc, m_valid, m_ready              : output byte stream
// Optional macro OLED_AUTO_REFRESH_EN: start held high in FINISH restarts the
// next frame immediately with busy kept high.
module oled_page_streamer
  import oled_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       fb_re,
  output logic [7:0] fb_xpos,
  output logic [7:0] fb_ypos,
  output logic       fb_r_mode,
  input  logic [7:0] fb_dout,
  output logic [7:0] m_data,
  output logic       m_dc,
  output logic       m_valid,
  input  logic       m_ready
);

  localparam logic [6:0] COL_LAST  = 7'(H_PIXELS - 1);
  localparam logic [2:0] PAGE_LAST = 3'(PAGES - 1);

  state_t     r_state;
  logic [2:0] r_page;
  logic [6:0] r_col;
  logic       r_busy;
  logic       r_done;
  logic       r_fb_re;
  logic [7:0] r_fb_xpos;
  logic [7:0] r_fb_ypos;
  logic [7:0] r_m_data;
  logic       r_m_dc;
  logic       r_m_valid;
  logic       w_hs;

  assign w_hs = r_m_valid & m_ready;

  // All outputs are registered: each one is loaded on the transition into the
  // state that owns it, so it is already valid during that state's cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_page    <= '0;
      r_col     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_fb_re   <= 1'b0;
      r_fb_xpos <= '0;
      r_fb_ypos <= '0;
      r_m_data  <= '0;
      r_m_dc    <= 1'b0;
      r_m_valid <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state   <= ST_CMD_PAGE;
            r_page    <= '0;
            r_col     <= '0;
            r_busy    <= 1'b1;
            r_m_valid <= 1'b1;
            r_m_dc    <= 1'b0;
            r_m_data  <= CMD_PAGE_BASE;
          end
        end
        ST_CMD_PAGE: begin
          if (w_hs) begin
            r_state  <= ST_CMD_COLLO;
            r_m_data <= CMD_COL_LO;
          end
        end
        ST_CMD_COLLO: begin
          if (w_hs) begin
            r_state  <= ST_CMD_COLHI;
            r_m_data <= CMD_COL_HI;
          end
        end
        ST_CMD_COLHI: begin
          if (w_hs) begin
            r_state   <= ST_FETCH;
            r_m_valid <= 1'b0;
            r_col     <= '0;
            r_fb_re   <= 1'b1;
            r_fb_xpos <= '0;
            r_fb_ypos <= {2'b00, r_page, 3'b000};
          end
        end
        ST_FETCH: begin
          r_state   <= ST_CAPTURE;
          r_fb_re   <= 1'b0;
          r_fb_xpos <= '0;
          r_fb_ypos <= '0;
        end
        ST_CAPTURE: begin
          // Framebuffer bit7 is the top row; SSD1306 expects the top row in bit0.
          r_state   <= ST_SEND_DATA;
          r_m_data  <= {fb_dout[0], fb_dout[1], fb_dout[2], fb_dout[3],
                        fb_dout[4], fb_dout[5], fb_dout[6], fb_dout[7]};
          r_m_dc    <= 1'b1;
          r_m_valid <= 1'b1;
        end
        ST_SEND_DATA: begin
          if (w_hs) begin
            if (r_col != COL_LAST) begin
              r_state   <= ST_FETCH;
              r_col     <= r_col + 7'd1;
              r_m_valid <= 1'b0;
              r_fb_re   <= 1'b1;
              r_fb_xpos <= {1'b0, r_col + 7'd1};
              r_fb_ypos <= {2'b00, r_page, 3'b000};
            end else if (r_page != PAGE_LAST) begin
              // m_valid stays high straight into the next page command.
              r_state  <= ST_CMD_PAGE;
              r_page   <= r_page + 3'd1;
              r_m_dc   <= 1'b0;
              r_m_data <= CMD_PAGE_BASE | {5'b00000, r_page + 3'd1};
            end else begin
              r_state   <= ST_FINISH;
              r_m_valid <= 1'b0;
              r_m_dc    <= 1'b0;
              r_m_data  <= '0;
              r_done    <= 1'b1;
`ifdef OLED_AUTO_REFRESH_EN
              r_busy    <= ~start;
`else
              r_busy    <= 1'b0;
`endif
            end
          end
        end
        ST_FINISH: begin
`ifdef OLED_AUTO_REFRESH_EN
          if (start) begin
            r_state   <= ST_CMD_PAGE;
            r_page    <= '0;
            r_col     <= '0;
            r_busy    <= 1'b1;
            r_m_valid <= 1'b1;
            r_m_dc    <= 1'b0;
            r_m_data  <= CMD_PAGE_BASE;
          end else begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
`else
          r_state <= ST_IDLE;
`endif
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign fb_re     = r_fb_re;
  assign fb_xpos   = r_fb_xpos;
  assign fb_ypos   = r_fb_ypos;
  assign fb_r_mode = 1'b1;
  assign m_data    = r_m_data;
  assign m_dc      = r_m_dc;
  assign m_valid   = r_m_valid;

endmodule

// File: tb/tb_oled_page_streamer.sv
// tb_oled_page_streamer: scoreboard bench for oled_page_streamer. Stimulus
// pushes every expected {dc,data} byte of a frame into a queue; a negedge
// monitor pops and compares on each handshake, and checks stall stability.
module tb_oled_page_streamer;
  import oled_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       m_ready = 1'b0;
  logic [7:0] fb_dout = '0;
  logic       busy, done, fb_re, fb_r_mode, m_dc, m_valid;
  logic [7:0] fb_xpos, fb_ypos, m_data;

  logic [7:0] fbmem [128][8];
  logic [8:0] sb [$];

  int tests = 0;
  int fails = 0;
  int hs = 0;
  int busy_cnt = 0;
  int done_cnt = 0;
  logic [7:0] last_x = '0;
  logic [7:0] last_y = '0;
  bit   rdy_rand = 1'b0;
  logic stall_prev = 1'b0;
  logic [7:0] prev_data = '0;
  logic prev_dc = 1'b0;

  oled_page_streamer dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .fb_re(fb_re), .fb_xpos(fb_xpos), .fb_ypos(fb_ypos), .fb_r_mode(fb_r_mode),
    .fb_dout(fb_dout), .m_data(m_data), .m_dc(m_dc), .m_valid(m_valid),
    .m_ready(m_ready)
  );

  always #5 clk = ~clk;

  // Framebuffer model: data valid the cycle after fb_re, bit7 = top row.
  always @(posedge clk) if (fb_re) fb_dout <= fbmem[fb_xpos[6:0]][fb_ypos[5:3]];

  initial forever begin
    @(posedge clk);
    #1;
    m_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] panel_byte(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  task automatic push_frame();
    for (int p = 0; p < 8; p++) begin
      sb.push_back({1'b0, 8'hB0 | 8'(p)});
      sb.push_back({1'b0, 8'h00});
      sb.push_back({1'b0, 8'h10});
      for (int c = 0; c < 128; c++) sb.push_back({1'b1, panel_byte(fbmem[c][p])});
    end
  endtask

  task automatic fill_fb(input bit rnd);
    for (int c = 0; c < 128; c++)
      for (int p = 0; p < 8; p++) fbmem[c][p] = rnd ? 8'($urandom) : 8'h00;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      if (fb_re) begin
        last_x = fb_xpos;
        last_y = fb_ypos;
      end
      if (stall_prev)
        check("stall_hold", {23'd0, m_valid, m_dc, m_data}, {23'd0, 1'b1, prev_dc, prev_data});
      if (m_valid && m_ready) begin
        if (sb.size() == 0) check("sb_underflow", 32'(hs), 32'hFFFF_FFFF);
        else check($sformatf("byte%0d", hs), {23'd0, m_dc, m_data}, {23'd0, sb.pop_front()});
        hs++;
      end
      stall_prev = m_valid && !m_ready;
      prev_data  = m_data;
      prev_dc    = m_dc;
    end
  end

  // Runs one frame from a start pulse; optionally re-pulses start at a byte count.
  task automatic frame_test(input bit chk_busy, input int repulse_at);
    int  n;
    bit  pulsed;
    sb.delete();
    push_frame();
    busy_cnt = 0; done_cnt = 0; hs = 0; pulsed = 1'b0; n = 0;
    @(negedge clk); #1 start = 1'b1;
    while (done_cnt == 0 && n < 20000) begin
      @(negedge clk); #1;
      start = 1'b0;
      if (repulse_at > 0 && !pulsed && hs >= repulse_at) begin
        start = 1'b1;
        pulsed = 1'b1;
      end
      n++;
    end
    start = 1'b0;
    if (n >= 20000) check("frame_timeout", 32'(n), 32'd0);
    repeat (20) @(negedge clk);
    #1;
    check("done_count", 32'(done_cnt), 32'd1);
    check("handshakes", 32'(hs), 32'd1048);
    check("sb_left", 32'(sb.size()), 32'd0);
    check("busy_after", {31'd0, busy}, 32'd0);
    if (chk_busy) check("busy_cycles", 32'(busy_cnt), 32'd3096);
  endtask

  initial begin
    int n;
    int d;
    fill_fb(1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("rst_outputs", {busy, done, fb_re, fb_xpos, fb_ypos, m_data, m_dc, m_valid}, '0);
    check("rst_rmode", {31'd0, fb_r_mode}, 32'd1);
    @(negedge clk) rst = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    check("idle_outputs", {busy, done, fb_re, fb_xpos, fb_ypos, m_data, m_dc, m_valid}, '0);

    // Pixel (0,0): top row of page 0 column 0 -> data byte 0x01.
    fill_fb(1'b0);
    fbmem[0][0] = 8'h80;
    frame_test(1'b1, 0);

    // Pixel (127,63): bottom row of page 7 column 127 -> final byte 0x80.
    fill_fb(1'b0);
    fbmem[127][7] = 8'h01;
    frame_test(1'b1, 0);
    check("last_xpos", 32'(last_x), 32'd127);
    check("last_ypos", 32'(last_y), 32'd56);

    // Random framebuffer with random backpressure.
    fill_fb(1'b1);
    rdy_rand = 1'b1;
    frame_test(1'b0, 0);
    rdy_rand = 1'b0;

    // start re-pulsed mid-frame is ignored.
    fill_fb(1'b1);
    frame_test(1'b1, 300);

    // Reset after byte 500 abandons the frame with no done pulse.
    sb.delete();
    push_frame();
    hs = 0; done_cnt = 0; n = 0;
    @(negedge clk); #1 start = 1'b1;
    @(negedge clk); #1 start = 1'b0;
    while (hs < 500 && n < 5000) begin
      @(negedge clk); #1;
      n++;
    end
    if (n >= 5000) check("rst_wait_timeout", 32'(n), 32'd0);
    @(posedge clk); #1 rst = 1'b1;
    #1;
    check("rst_mid_valid", {31'd0, m_valid}, 32'd0);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    sb.delete();
    d = done_cnt;
    repeat (10) @(negedge clk);
    #1;
    check("rst_no_done", 32'(done_cnt), 32'(d));
    frame_test(1'b1, 0);

`ifdef OLED_AUTO_REFRESH_EN
    begin
      int gap;
      sb.delete();
      push_frame();
      push_frame();
      done_cnt = 0; hs = 0; n = 0; gap = 0;
      @(negedge clk); #1 start = 1'b1;
      while (done_cnt < 2 && n < 20000) begin
        @(negedge clk); #1;
        if (done_cnt == 1 && !busy) gap++;
        n++;
      end
      start = 1'b0;
      repeat (10) @(negedge clk);
      #1;
      check("auto_done", 32'(done_cnt), 32'd2);
      check("auto_gap", 32'(gap), 32'd0);
      check("auto_hs", 32'(hs), 32'd2096);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/oled_page_streamer.md
Name: oled_page_streamer

Overview:
- Downstream consumer of the monochrome framebuffer. On a start request it walks the 128x64 frame page by page.
- For each page it emits SSD1306 page-addressing command bytes, then 128 column bytes read from the framebuffer in column mode.
- Bytes are bit-reordered into panel format and presented on a valid/ready byte stream feeding the SPI/I2C transmitter.
- Sits between framebuffer_monochrome and the OLED serial link.

Parameters:
- H_PIXELS, 128, horizontal resolution in pixels (columns per page).
- V_PIXELS, 64, vertical resolution in pixels; PAGES = V_PIXELS/8.

Ports:
- clk  in  1  module clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  frame refresh request, sampled in IDLE
- busy  out  1  high from the cycle after start is accepted until the cycle done pulses
- done  out  1  one-cycle pulse after the last data byte handshake of a frame
- fb_re  out  1  framebuffer read enable
- fb_xpos  out  8  framebuffer read X (column)
- fb_ypos  out  8  framebuffer read Y (page*8)
- fb_r_mode  out  1  constant 1 (column read)
- fb_dout  in  8  framebuffer read data; valid the cycle after fb_re; bit7 = top row
- m_data  out  8  stream byte
- m_dc  out  1  0 = command byte, 1 = display data byte
- m_valid  out  1  stream byte valid
- m_ready  in  1  downstream accepts byte when m_valid && m_ready at posedge clk

Behaviour:
- Reset (asynchronous, active-high, any state) -> IDLE; all outputs 0 except fb_r_mode = 1; page and column counters = 0. Reset mid-frame abandons the frame; no done pulse.
- FSM states: IDLE, CMD_PAGE, CMD_COLLO, CMD_COLHI, FETCH, CAPTURE, SEND_DATA, FINISH.
- IDLE: start = 1 -> CMD_PAGE with page = 0; busy asserts next cycle.
- CMD_PAGE / CMD_COLLO / CMD_COLHI:
  - m_valid = 1, m_dc = 0.
  - m_data = 0xB0|page, 0x00, 0x10 respectively.
  - Advance on handshake; CMD_COLHI -> FETCH with col = 0.
- FETCH: fb_re = 1 for exactly one cycle, fb_xpos = col, fb_ypos = page*8 -> CAPTURE.
- CAPTURE: register m_data[i] = fb_dout[7-i] (bit0 = top row, SSD1306 order), m_dc = 1, m_valid = 1 -> SEND_DATA.
- SEND_DATA: hold byte until handshake.
  - col < H_PIXELS-1: col+1 -> FETCH.
  - Else if page < PAGES-1: page+1 -> CMD_PAGE.
  - Else -> FINISH.
- FINISH: done = 1 for one cycle, busy = 0 -> IDLE.
- Backpressure: while m_valid && !m_ready, m_data and m_dc stay stable and no fb_re is issued. m_valid never drops without a handshake (except on reset).
- fb_re is asserted only in FETCH; fb_xpos/fb_ypos are 0 outside FETCH.
- Throughput with m_ready tied high: 1 cycle per command byte, 3 cycles per data byte. Frame = PAGES*(3 + H_PIXELS) = 1048 handshakes, 8*(3 + 384) = 3096 busy cycles.
- start while busy: ignored (no restart, no queueing).
- Counters: col is 7 bits, page is 3 bits. fb_ypos = {page, 3'b000} zero-extended to 8 bits. No wrap occurs within a frame.

Optional Feature:
- Macro: OLED_AUTO_REFRESH_EN.
- Defined: in FINISH, if start is high, done pulses and the FSM goes directly to CMD_PAGE with page = 0; busy stays high. Holding start high streams frames back-to-back.
- Undefined: FINISH always returns to IDLE; start is a request pulse.

Decomposition:
- Shared package oled_pkg holds:
  - H_PIXELS, V_PIXELS, PAGES
  - SSD1306 constants: CMD_PAGE_BASE = 0xB0, CMD_COL_LO = 0x00, CMD_COL_HI = 0x10
  - FSM state encoding
- No sub-module: a single FSM with page/column counters and one output register. The bit reversal is inline.

Test Plan:
- Reset idle: assert rst mid-cycle -> all outputs 0, fb_r_mode = 1, outputs remain 0 with start low.
- Pixel (0,0) set in the framebuffer model, m_ready = 1, start pulse -> first bytes 0xB0/0x00/0x10 with dc = 0, then 0x01 with dc = 1; remaining 1044 bytes are commands or 0x00; done pulses once after 3096 busy cycles.
- Pixel (127,63) set -> page 7 command 0xB7; final data byte 0x80; fb_xpos = 127, fb_ypos = 56 on the last fetch.
- Random m_ready (50%) with a random framebuffer -> m_data/m_dc stable while stalled; exactly 1048 handshakes; data matches the bit-reversed column model.
- start re-pulsed at byte 300 -> ignored, single done. Reset at byte 500 -> m_valid/busy 0 immediately, no done; next start begins with 0xB0.
- OLED_AUTO_REFRESH_EN defined, start held high -> two back-to-back frames, done pulses twice, busy never drops between frames.
